store_narrow_unit: RTL and testbench

- Store-side counterpart of the load-path sign extender in the MIPS datapath: narrows a 32-bit register value to byte, halfword or word width and places it in the correct lane of a word-addressed data RAM.
- The RAM has no byte enables, so sub-word stores run a read-modify-write sequence through a small FSM.
- Misaligned or illegal-size stores raise an address-error-store (AdES) pulse instead of touching memory.
- Sits between the MEM-stage control and the data RAM.

---
 rtl/store_narrow_unit.sv | 93 +++++++++
 tb/tb_store_narrow_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/store_narrow_unit.sv
// store_narrow_unit: narrows a register value to byte/half/word and stores it into a word-only RAM,
// using read-modify-write for sub-word stores and raising AdES on misaligned or illegal sizes.
module store_narrow_unit #(
  parameter int ADDR_W = 32,
  parameter bit BIG_ENDIAN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              exc,
  output logic [ADDR_W-1:0] badvaddr
);
  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, EXC} state_t;
  state_t state;
  logic [1:0] lo_q;
  logic half_q;
  logic [15:0] data_q;
  logic [31:0] merged;
  logic [1:0] k;
  logic h;
  logic illegal;
  assign illegal = (req_size == 2'b11) | (req_size == 2'b01 & req_addr[0]) | (req_size == 2'b10 & |req_addr[1:0]);
  assign req_ready = state == IDLE;
  assign k = lo_q ^ {2{BIG_ENDIAN}};
  assign h = lo_q[1] ^ BIG_ENDIAN;
  always_comb begin
    merged = mem_rdata;
    if (half_q) merged[16*h +: 16] = data_q;
    else merged[8*k +: 8] = data_q[7:0];
  end
  // Strobes are single-cycle pulses; address, write data and badvaddr hold until overwritten.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
      exc       <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      badvaddr  <= '0;
      lo_q      <= '0;
      half_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
      exc       <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          lo_q   <= req_addr[1:0];
          half_q <= req_size[0];
          data_q <= req_data[15:0];
          if (illegal) begin
            state    <= EXC;
            exc      <= 1'b1;
            badvaddr <= req_addr;
          end else begin
            mem_addr <= req_addr[ADDR_W-1:2];
            if (req_size[1]) begin
              state     <= WRITE;
              mem_wr_en <= 1'b1;
              done      <= 1'b1;
              mem_wdata <= req_data;
            end else begin
              state     <= READ;
              mem_rd_en <= 1'b1;
            end
          end
        end
        READ: state <= MERGE;
        MERGE: begin
          state     <= WRITE;
          mem_wr_en <= 1'b1;
          done      <= 1'b1;
          mem_wdata <= merged;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_store_narrow_unit.sv
// tb_store_narrow_unit: little- and big-endian instances driven by the same directed stores,
// checked every cycle against a schedule-based reference model plus hand-computed RAM contents.
module tb_store_narrow_unit;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic req_valid = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_data = 0;
  logic ready0, ready1, rd0, rd1, wr0, wr1, done0, done1, exc0, exc1;
  logic [29:0] addr0, addr1;
  logic [31:0] wd0, wd1, bv0, bv1, rdata0 = 0, rdata1 = 0;
  logic [31:0] ram0[16], ram1[16];
  int checks = 0, errors = 0, dn_total = 0;

  store_narrow_unit #(.ADDR_W(32), .BIG_ENDIAN(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready0), .req_size(req_size),
    .req_addr(req_addr), .req_data(req_data), .mem_addr(addr0), .mem_rd_en(rd0), .mem_rdata(rdata0),
    .mem_wr_en(wr0), .mem_wdata(wd0), .done(done0), .exc(exc0), .badvaddr(bv0));
  store_narrow_unit #(.ADDR_W(32), .BIG_ENDIAN(1)) dut_be (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready1), .req_size(req_size),
    .req_addr(req_addr), .req_data(req_data), .mem_addr(addr1), .mem_rd_en(rd1), .mem_rdata(rdata1),
    .mem_wr_en(wr1), .mem_wdata(wd1), .done(done1), .exc(exc1), .badvaddr(bv1));

  initial for (int i = 0; i < 16; i++) begin ram0[i] = 0; ram1[i] = 0; end
  always @(posedge clk) begin
    if (rd0) rdata0 <= ram0[addr0[3:0]];
    if (wr0) ram0[addr0[3:0]] <= wd0;
    if (rd1) rdata1 <= ram1[addr1[3:0]];
    if (wr1) ram1[addr1[3:0]] <= wd1;
  end

  // Reference model: on accept, schedule the strobes of future cycles in an 8-slot ring.
  int cyc = 0, busy_until = 0, s1, s3, wa, sl;
  bit started = 0;
  bit rd_s[8], wr_s[8], dn_s[8], ex_s[8], ad_v[8], bv_v[8];
  logic [29:0] ad_s[8];
  logic [31:0] wd0_s[8], wd1_s[8], bv_s[8], ref0[16], ref1[16];
  bit e_rd, e_wr, e_dn, e_ex;
  logic [29:0] e_addr;
  logic [31:0] e_wd0, e_wd1, e_bv;
  initial for (int i = 0; i < 16; i++) begin ref0[i] = 0; ref1[i] = 0; end

  function automatic logic [31:0] merge(input logic [31:0] w, d, a, input logic [1:0] sz, input bit be);
    int n;
    logic [31:0] m;
    if (sz == 0) begin
      n = a % 4;
      if (be) n = 3 - n;
      m = 32'hFF << (8 * n);
      return (w & ~m) | ((d & 32'hFF) << (8 * n));
    end
    n = (a / 2) % 2;
    if (be) n = 1 - n;
    m = 32'hFFFF << (16 * n);
    return (w & ~m) | ((d & 32'hFFFF) << (16 * n));
  endfunction

  function automatic bit legal(input logic [1:0] sz, input logic [31:0] a);
    return sz == 2 ? a % 4 == 0 : sz == 1 ? a % 2 == 0 : sz == 0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        rd_s[i] = 0; wr_s[i] = 0; dn_s[i] = 0; ex_s[i] = 0; ad_v[i] = 0; bv_v[i] = 0;
      end
      e_addr = 0; e_wd0 = 0; e_wd1 = 0; e_bv = 0;
      busy_until = cyc + 1;
      started = 1;
    end else if (started && req_valid && cyc >= busy_until) begin
      s1 = (cyc + 1) % 8;
      s3 = (cyc + 3) % 8;
      wa = (req_addr / 4) % 16;
      if (!legal(req_size, req_addr)) begin
        ex_s[s1] = 1; bv_v[s1] = 1; bv_s[s1] = req_addr;
        busy_until = cyc + 2;
      end else if (req_size == 2) begin
        wr_s[s1] = 1; dn_s[s1] = 1; ad_v[s1] = 1; ad_s[s1] = req_addr / 4;
        wd0_s[s1] = req_data; wd1_s[s1] = req_data;
        busy_until = cyc + 2;
      end else begin
        rd_s[s1] = 1; ad_v[s1] = 1; ad_s[s1] = req_addr / 4;
        wr_s[s3] = 1; dn_s[s3] = 1;
        wd0_s[s3] = merge(ref0[wa], req_data, req_addr, req_size, 0);
        wd1_s[s3] = merge(ref1[wa], req_data, req_addr, req_size, 1);
        busy_until = cyc + 4;
      end
    end
    cyc++;
    sl = cyc % 8;
    e_rd = rd_s[sl]; e_wr = wr_s[sl]; e_dn = dn_s[sl]; e_ex = ex_s[sl];
    if (ad_v[sl]) e_addr = ad_s[sl];
    if (bv_v[sl]) e_bv = bv_s[sl];
    if (wr_s[sl]) begin
      e_wd0 = wd0_s[sl]; e_wd1 = wd1_s[sl];
      ref0[e_addr[3:0]] = e_wd0; ref1[e_addr[3:0]] = e_wd1;
    end
    rd_s[sl] = 0; wr_s[sl] = 0; dn_s[sl] = 0; ex_s[sl] = 0; ad_v[sl] = 0; bv_v[sl] = 0;
  end

  task automatic chk(input string nm, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) if (started) begin
    chk("ready0", 32'(ready0), 32'(cyc >= busy_until));
    chk("ready1", 32'(ready1), 32'(cyc >= busy_until));
    chk("rd0", 32'(rd0), 32'(e_rd));
    chk("rd1", 32'(rd1), 32'(e_rd));
    chk("wr0", 32'(wr0), 32'(e_wr));
    chk("wr1", 32'(wr1), 32'(e_wr));
    chk("done0", 32'(done0), 32'(e_dn));
    chk("done1", 32'(done1), 32'(e_dn));
    chk("exc0", 32'(exc0), 32'(e_ex));
    chk("exc1", 32'(exc1), 32'(e_ex));
    chk("addr0", 32'(addr0), 32'(e_addr));
    chk("addr1", 32'(addr1), 32'(e_addr));
    chk("wdata0", wd0, e_wd0);
    chk("wdata1", wd1, e_wd1);
    chk("bv0", bv0, e_bv);
    chk("bv1", bv1, e_bv);
    if (done0 === 1'b1) dn_total++;
  end

  task automatic do_req(input logic [1:0] sz, input logic [31:0] a, d);
    @(negedge clk);
    req_valid = 1; req_size = sz; req_addr = a; req_data = d;
    @(negedge clk);
    req_valid = 0; req_size = 2'($urandom); req_addr = $urandom; req_data = $urandom;
    repeat (5) @(negedge clk);
  endtask

  int base;
  initial begin
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    do_req(2, 32'h10, 32'hDEADBEEF);
    chk("sw_ram0", ram0[4], 32'hDEADBEEF);
    chk("sw_ram1", ram1[4], 32'hDEADBEEF);
    do_req(2, 32'h10, 32'h11223344);
    do_req(0, 32'h12, 32'hFFFFFFAA);
    chk("sb_ram0", ram0[4], 32'h11AA3344);
    chk("sb_ram1", ram1[4], 32'h1122AA44);
    do_req(2, 32'h10, 32'h11223344);
    do_req(1, 32'h12, 32'h0000BEEF);
    chk("sh_ram0", ram0[4], 32'hBEEF3344);
    chk("sh_ram1", ram1[4], 32'h1122BEEF);
    do_req(1, 32'h13, 32'h12345678);
    chk("exc_sh_bv", bv0, 32'h13);
    do_req(2, 32'h1A, 32'h12345678);
    chk("exc_sw_bv", bv0, 32'h1A);
    do_req(3, 32'h24, 32'h12345678);
    chk("exc_sz_bv", bv1, 32'h24);
    chk("exc_ram_untouched", ram0[4], 32'hBEEF3344);
    base = dn_total;
    @(negedge clk);
    req_valid = 1; req_size = 0; req_addr = 32'h21; req_data = 32'h00000055;
    repeat (12) @(negedge clk);
    req_valid = 0;
    repeat (6) @(negedge clk);
    chk("burst_done", 32'(dn_total - base), 32'd3);
    chk("burst_ram0", ram0[8], 32'h00005500);
    chk("burst_ram1", ram1[8], 32'h00550000);
    @(negedge clk);
    req_valid = 1; req_size = 0; req_addr = 32'h20; req_data = 32'h77;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    chk("abort_ram0", ram0[8], 32'h00005500);
    chk("abort_ready", 32'(ready0), 32'd1);
    chk("abort_wdata", wd0, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
